rdx_resolve_31: RTL and testbench
=================================

RDX_RESOLVE_31 -- requirements
Module: rdx_resolve_31

Interface
REQ-001 SHALL have parameter WIDTH, default 31, meaning width of each redundant input vector.
REQ-002 SHALL have parameter CHUNK, default 8, meaning bits resolved per compute cycle.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning s_in/e_in hold a valid redundant operand pair.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts an operand pair this cycle.
REQ-007 SHALL have port s_in, input, WIDTH, meaning the sum vector from the upstream cell row.
REQ-008 SHALL have port e_in, input, WIDTH, meaning the carry vector from the upstream cell row, at the same bit weights as s_in.
REQ-009 SHALL have port out_valid, output, 1, meaning result holds a resolved value.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream accepts result this cycle.
REQ-011 SHALL have port result, output, WIDTH+1, meaning binary value s_in + e_in; MSB is the final carry-out.
REQ-012 SHALL have port busy, output, 1, meaning state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, ADD, DONE.
REQ-014 In IDLE: in_ready=1, out_valid=0; in_valid=1 at a clock edge SHALL register s_in, e_in (zero-extended to NCHUNK*CHUNK bits, NCHUNK=ceil((WIDTH+1)/CHUNK), 4 at defaults), clear chunk index and carry, and enter ADD.
REQ-015 In ADD: each cycle SHALL add chunk[idx] of both operands plus carry register, write the CHUNK-bit sum into result chunk idx, store carry-out, increment idx.
REQ-016 Leaving ADD SHALL occur on the edge that processes chunk NCHUNK-1, entering DONE; carry beyond bit NCHUNK*CHUNK-1 SHALL be discarded (unreachable at defaults).
REQ-017 Latency: out_valid SHALL rise NCHUNK edges after the accepting edge (4 at defaults).
REQ-018 In DONE: out_valid=1, result stable; out_ready=1 at an edge SHALL complete transfer and return to IDLE.
REQ-019 in_ready SHALL be 0 in ADD and DONE; no same-cycle accept on the DONE->IDLE edge; one-cycle IDLE gap minimum between operands.
REQ-020 in_valid and s_in/e_in changes while in_ready=0 SHALL be ignored; registered operands SHALL not change until next accept.
REQ-021 out_ready while out_valid=0 SHALL have no effect; result SHALL hold indefinitely in DONE while out_ready=0.
REQ-022 result bits above WIDTH SHALL not be driven by anything but the resolved sum (result[WIDTH] = carry-out of bit WIDTH-1).
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 rst=1 SHALL, asynchronously and at any state including mid-ADD, force state IDLE, idx=0, carry=0, result=0, out_valid=0, busy=0.
REQ-025 in_ready SHALL be 1 in the first cycle rst is low; an operation aborted by reset SHALL produce no output.

Verification
REQ-026 s_in=0x12345678, e_in=0x00001111, accept, out_ready=1 -> out_valid high exactly 4 edges after accept, result=0x012346789 (32-bit: 0x12346789).
REQ-027 s_in=0x000000FF, e_in=0x00000001 -> result=0x00000100 (carry crosses chunk 0->1 boundary).
REQ-028 s_in=0x7FFFFFFF, e_in=0x00000001 -> result=0x80000000 (carry ripples all chunks into result[31]).
REQ-029 Accept, hold out_ready=0 for 10 cycles, toggle in_valid/s_in -> result and out_valid stable, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-030 Assert rst during 2nd ADD cycle -> outputs zero immediately, in_ready=1 after release, no out_valid for aborted operand; next operand 0+0 -> result=0.
REQ-031 Back-to-back operands with in_valid held high and out_ready=1 -> one result per 6 cycles, each matching s_in+e_in, no operand dropped or duplicated.

Source files
------------

// File: rtl/rdx_resolve_31.sv
// rtl/rdx_resolve_31.sv - chunk-serial resolver turning a redundant sum/carry pair into a binary value
//
// Purpose: accepts one redundant operand pair (s_in, e_in) through a ready/valid handshake.
//          It adds the two vectors CHUNK bits per cycle with a rippling carry register.
//          It then presents the (WIDTH+1)-bit binary result until downstream takes it.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   s_in/e_in hold a valid operand pair
//   in_ready   out  operand pair accepted this cycle (IDLE only)
//   s_in       in   [WIDTH-1:0] sum vector
//   e_in       in   [WIDTH-1:0] carry vector, same bit weights as s_in
//   out_valid  out  result holds a resolved value (DONE only)
//   out_ready  in   downstream accepts result this cycle
//   result     out  [WIDTH:0] s_in + e_in, MSB is the final carry-out
//   busy       out  state is not IDLE

module rdx_resolve_31 #(
  parameter int WIDTH = 31,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] e_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             busy
);

  // Enough chunks to hold the full WIDTH+1 bit sum, so the carry out of bit WIDTH-1
  // always lands inside the result register.
  localparam int NCHUNK = (WIDTH + 1 + CHUNK - 1) / CHUNK;
  localparam int TOTW   = NCHUNK * CHUNK;
  localparam int PADW   = TOTW - WIDTH;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [TOTW-1:0]   s_q, s_d;
  logic [TOTW-1:0]   e_q, e_d;
  logic [TOTW-1:0]   res_q, res_d;

  logic [CHUNK-1:0]  s_chunk;
  logic [CHUNK-1:0]  e_chunk;
  logic [CHUNK:0]    chunk_sum;
  logic              last_chunk;

  // Operand chunks selected by the running index; one CHUNK-bit add per ADD cycle.
  assign s_chunk    = s_q[idx_q*CHUNK +: CHUNK];
  assign e_chunk    = e_q[idx_q*CHUNK +: CHUNK];
  assign chunk_sum  = {1'b0, s_chunk} + {1'b0, e_chunk} + {{CHUNK{1'b0}}, carry_q};
  assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      e_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      e_q     <= e_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    s_d       = s_q;
    e_d       = e_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          s_d     = {{PADW{1'b0}}, s_in};
          e_d     = {{PADW{1'b0}}, e_in};
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        res_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        if (last_chunk) begin
          // Carry out of the top chunk is beyond the result width and is dropped.
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        // No accept on the DONE->IDLE edge; the next operand waits one IDLE cycle.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign result = res_q[WIDTH:0];
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_rdx_resolve_31.sv
// tb/tb_rdx_resolve_31.sv - self-checking bench for rdx_resolve_31

module tb_rdx_resolve_31;

  localparam int W = 31;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  s_in;
  logic [W-1:0]  e_in;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    result;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int cyc      = 0;

  logic [W:0] sb_q[$];

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] e;
    logic [W:0]   exp;
  } vec_t;

  vec_t tbl[8];

  rdx_resolve_31 #(.WIDTH(W), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .e_in      (e_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: sample half a cycle before the edge that acts on the handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (in_valid && in_ready)
        sb_q.push_back({1'b0, s_in} + {1'b0, e_in});
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          chk("sb_result", 64'(result), 64'(sb_q.pop_front()));
          n_pops++;
        end
      end
    end
  end

  task automatic wait_ready();
    logic found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        found = 1'b1;
        break;
      end
    end
    chk("ready_timeout", 64'(found), 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] e, input logic [W:0] exp);
    int lat = 0;
    out_ready = 1'b1;
    s_in      = s;
    e_in      = e;
    in_valid  = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd4);
    chk("result", 64'(result), 64'(exp));
    @(posedge clk);
    #1;
    chk("post_xfer_out_valid", 64'(out_valid), 64'd0);
    chk("post_xfer_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic       seen;
    logic [W:0] exp;
    int         prev_t;
    int         pops0;
    logic       found;

    tbl[0] = '{31'h12345678, 31'h00001111, 32'h12346789};
    tbl[1] = '{31'h000000FF, 31'h00000001, 32'h00000100};
    tbl[2] = '{31'h7FFFFFFF, 31'h00000001, 32'h80000000};
    tbl[3] = '{31'h00000000, 31'h00000000, 32'h00000000};
    tbl[4] = '{31'h7FFFFFFF, 31'h7FFFFFFF, 32'hFFFFFFFE};
    tbl[5] = '{31'h00FF00FF, 31'h00010001, 32'h01000100};
    tbl[6] = '{31'h55555555, 31'h2AAAAAAB, 32'h80000000};
    tbl[7] = '{31'h0000FFFF, 31'h00FF0001, 32'h01000000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s_in      = '0;
    e_in      = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("first_cycle_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].s, tbl[i].e, tbl[i].exp);

    // Stall in DONE while input side is toggled.
    exp = 32'h2468ACF0;
    out_ready = 1'b0;
    s_in      = 31'h12345678;
    e_in      = 31'h12345678;
    in_valid  = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("hold_reach_done", 64'(found), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result", 64'(result), 64'(exp));
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      in_valid = ~in_valid;
      s_in     = W'($urandom);
      e_in     = W'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_in_ready", 64'(in_ready), 64'd1);
    chk("hold_release_busy", 64'(busy), 64'd0);

    // Reset during the second ADD cycle.
    s_in     = 31'h12345678;
    e_in     = 31'h00001111;
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("abort_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_output", 64'(seen), 64'd0);
    run_op('0, '0, '0);

    // Back-to-back stream with in_valid held high.
    pops0     = n_pops;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev_t    = 0;
    for (int k = 0; k < 6; k++) begin
      s_in = W'($urandom);
      e_in = W'($urandom);
      wait_ready();
      if (k > 0) chk("b2b_spacing", 64'(cyc - prev_t), 64'd6);
      prev_t = cyc;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("b2b_count", 64'(n_pops - pops0), 64'd6);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
